// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM link: default frame geometry (used by both
// the transmit-side mux/serializer and the receive-side demux), the framer
// state encoding and the decoded per-cycle control word of the demux FSM.
// ---------------------------------------------------------------------------
package tdm_pkg;

  // Default frame geometry shared by both ends of the link.
  localparam int TDM_N_CH = 8;  // channels (slots) per frame
  localparam int TDM_W    = 1;  // bits per channel sample

  // Framer state: HUNT waits for the first sync, LOCKED tracks slots.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // Decoded actions for one accepted sample.
  typedef struct packed {
    logic wr_en;      // write din into the shadow register
    logic wr_slot0;   // shadow write goes to slot 0 instead of slot s
    logic cnt_inc;    // advance the slot counter (wraps at the last slot)
    logic cnt_load0;  // force the slot counter to 1 (slot 0 just written)
    logic commit;     // last slot accepted: move the frame to o
    logic err;        // sync seen on a slot other than 0
  } tdm_ctrl_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Slot index counter for the TDM demux. Counts 0..N_CH-1 and wraps
// explicitly at N_CH-1, so non power-of-two frame lengths work.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset, clears s to 0
//   inc    in   1      advance to the next slot (wraps after the last slot)
//   load0  in   1      slot 0 was just written: jump to slot 1 (wins over inc)
//   s      out  SEL_W  slot the next accepted sample will be written to
//   wrap   out  1      s is currently the last slot of the frame
// ---------------------------------------------------------------------------
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load0,
  output logic [SEL_W-1:0] s,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  assign wrap = (s == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (load0) begin
      s <= SEL_W'(1);
    end else if (inc) begin
      s <= wrap ? '0 : s + SEL_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8
// Receive side of the TDM link: rebuilds N_CH parallel channels from a
// serial line carrying one sample per slot, slot 0 first, with a sync marker
// on slot 0. Samples are collected in a shadow register; the whole frame is
// committed to o in one step together with a one-cycle o_valid strobe.
//
// Handshake: din/sync are consumed on every rising clk edge where
// din_valid=1; there is no back-pressure. sync is ignored when din_valid=0.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   din        in   W        serial sample for the current slot
//   din_valid  in   1        din is valid this cycle
//   sync       in   1        marks the sample as slot 0 of a frame
//   s          out  SEL_W    slot index the next accepted sample goes to
//   o          out  N_CH*W   last complete frame, slot k at o[k*W +: W]
//   o_valid    out  1        one-cycle pulse: o was updated
//   sync_err   out  1        one-cycle pulse: sync on a slot other than 0
//   dbg_state  out  1        framer state (HUNT / LOCKED) for observation
// ---------------------------------------------------------------------------
module tdm_demux_1x8
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int W     = TDM_W,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [SEL_W-1:0]  s,
  output logic [N_CH*W-1:0] o,
  output logic              o_valid,
  output logic              sync_err,
  output tdm_state_e        dbg_state
);

  tdm_state_e       state;
  tdm_state_e       state_nxt;
  tdm_ctrl_t        ctrl;
  logic [SEL_W-1:0] s_cnt;
  logic             last_slot;
  logic [SEL_W-1:0] wr_idx;

  // Slots 0..N_CH-2 only: the last slot goes straight into o on commit.
  logic [(N_CH-1)*W-1:0] shadow;

  tdm_slot_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.cnt_inc),
    .load0 (ctrl.cnt_load0),
    .s     (s_cnt),
    .wrap  (last_slot)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // Once locked the framer never drops back to HUNT on its own; a misplaced
  // sync simply realigns it.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (din_valid && sync) state_nxt = LOCKED;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = HUNT;
    endcase
  end

  // ---------------- FSM: decoded actions ----------------
  always_comb begin
    ctrl = '0;
    case (state)
      HUNT: begin
        if (din_valid && sync) begin
          ctrl.wr_en     = 1'b1;
          ctrl.wr_slot0  = 1'b1;
          ctrl.cnt_load0 = 1'b1;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (sync) begin
            // Sync always starts a new frame at slot 0. If it arrives
            // elsewhere the partial frame is abandoned (o is untouched).
            ctrl.wr_en    = 1'b1;
            ctrl.wr_slot0 = 1'b1;
            if (s_cnt != '0) begin
              ctrl.err       = 1'b1;
              ctrl.cnt_load0 = 1'b1;
            end else begin
              ctrl.cnt_inc = 1'b1;
            end
          end else if (last_slot) begin
            ctrl.commit  = 1'b1;
            ctrl.cnt_inc = 1'b1;
          end else begin
            ctrl.wr_en   = 1'b1;
            ctrl.cnt_inc = 1'b1;
          end
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign wr_idx = ctrl.wr_slot0 ? '0 : s_cnt;

  // ---------------- shadow register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (ctrl.wr_en) begin
      for (int k = 0; k < N_CH - 1; k++) begin
        if (wr_idx == SEL_W'(k)) shadow[k*W +: W] <= din;
      end
    end
  end

  // ---------------- output register and strobes ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o        <= '0;
      o_valid  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      o_valid  <= ctrl.commit;
      sync_err <= ctrl.err;
      if (ctrl.commit) o <= {din, shadow};
    end
  end

  assign s         = s_cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x8
// Self-checking bench for tdm_demux_1x8 (N_CH=8, W=1). A queue-based frame
// model predicts every output; a compare process checks the DUT against it
// on each falling edge, and directed scenarios add hand-computed checks.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x8;
  import tdm_pkg::*;

  localparam int N_CH  = 8;
  localparam int W     = 1;
  localparam int SEL_W = $clog2(N_CH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]      din = '0;
  logic              din_valid = 1'b0;
  logic              sync = 1'b0;
  logic [SEL_W-1:0]  s;
  logic [N_CH*W-1:0] o;
  logic              o_valid;
  logic              sync_err;
  tdm_state_e        dbg_state;

  tdm_demux_1x8 #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .s         (s),
    .o         (o),
    .o_valid   (o_valid),
    .sync_err  (sync_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame is a list of received samples; it is emitted when it reaches N_CH.
  logic [W-1:0]      frame_q[$];
  logic [W-1:0]      exp_q[$];
  bit                m_locked = 1'b0;
  int                m_slot   = 0;
  logic [N_CH*W-1:0] m_o      = '0;
  bit                m_ovalid = 1'b0;
  bit                m_err    = 1'b0;

  always @(posedge clk) begin
    m_ovalid = 1'b0;
    m_err    = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_slot   = 0;
      m_o      = '0;
      frame_q.delete();
    end else if (din_valid) begin
      if (sync) begin
        if (m_locked && m_slot != 0) m_err = 1'b1;
        m_locked = 1'b1;
        frame_q.delete();
        frame_q.push_back(din);
        m_slot = 1;
      end else if (m_locked) begin
        frame_q.push_back(din);
        m_slot = m_slot + 1;
        if (m_slot == N_CH) begin
          exp_q = frame_q;
          for (int k = 0; k < N_CH; k++) m_o[k*W +: W] = exp_q[k];
          m_ovalid = 1'b1;
          frame_q.delete();
          m_slot = 0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit check_en = 1'b0;
  int cyc = 0;
  int ov_cyc[$];
  int err_pulses = 0;

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      check("o", 64'(o), 64'(m_o));
      check("o_valid", 64'(o_valid), 64'(m_ovalid));
      check("sync_err", 64'(sync_err), 64'(m_err));
      check("s", 64'(s), 64'(m_slot));
      check("state", 64'(dbg_state), 64'(m_locked));
      if (o_valid) ov_cyc.push_back(cyc);
      if (sync_err) err_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic send(input logic [W-1:0] d, input logic sy);
    din = d; sync = sy; din_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input logic sy);
    din = W'($urandom_range(0, 1)); sync = sy; din_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic send_frame(input logic [N_CH*W-1:0] v, input bit gaps);
    for (int k = 0; k < N_CH; k++) begin
      if (gaps && k != 0) idle(1'b1);
      send(v[k*W +: W], k == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  int n_ov;
  initial begin
    // 1. reset with active-looking inputs
    rst = 1'b1; din = 1'b1; din_valid = 1'b1; sync = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o", 64'(o), 64'h00);
    check("rst_o_valid", 64'(o_valid), 64'h0);
    check("rst_s", 64'(s), 64'h0);
    check("rst_sync_err", 64'(sync_err), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(HUNT));
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0;
    check_en = 1'b1;

    // 2. HUNT ignores unsynced samples, then lock on 8'hca
    for (int k = 0; k < 8; k++) send(W'($urandom_range(0, 1)), 1'b0);
    check("hunt_s", 64'(s), 64'h0);
    check("hunt_no_ov", 64'(ov_cyc.size()), 64'h0);
    send_frame(8'hca, 1'b0);
    check("ca_o", 64'(o), 64'hca);
    check("ca_o_valid", 64'(o_valid), 64'h1);
    idle(1'b0);
    check("ca_o_valid_drop", 64'(o_valid), 64'h0);

    // 4. alternate-cycle gaps, sync on idle cycles must be ignored
    send_frame(8'ha5, 1'b1);
    check("a5_o", 64'(o), 64'ha5);

    // 3. back-to-back frames
    ov_cyc.delete();
    err_pulses = 0;
    send_frame(8'h0f, 1'b0);
    check("0f_o", 64'(o), 64'h0f);
    send_frame(8'h5a, 1'b0);
    check("5a_o", 64'(o), 64'h5a);
    check("b2b_pulses", 64'(ov_cyc.size()), 64'd2);
    if (ov_cyc.size() == 2) check("b2b_spacing", 64'(ov_cyc[1] - ov_cyc[0]), 64'd8);
    check("b2b_no_err", 64'(err_pulses), 64'd0);

    // 5. sync at slot 3: resync, new frame 8'h3c starts from that sample
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
    check("pre_resync_s", 64'(s), 64'd3);
    send(1'b0, 1'b1);
    check("resync_err", 64'(sync_err), 64'h1);
    check("resync_o", 64'(o), 64'h5a);
    check("resync_s", 64'(s), 64'd1);
    for (int k = 1; k < 8; k++) send(1'((8'h3c >> k) & 8'h1), 1'b0);
    check("3c_o", 64'(o), 64'h3c);
    check("3c_o_valid", 64'(o_valid), 64'h1);

    // 6. reset at slot 5 discards the partial frame
    for (int k = 0; k < 5; k++) send(1'b1, k == 0);
    check("pre_rst_s", 64'(s), 64'd5);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_o", 64'(o), 64'h00);
    check("midrst_state", 64'(dbg_state), 64'(HUNT));
    n_ov = ov_cyc.size();
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0);
    check("midrst_no_ov", 64'(ov_cyc.size()), 64'(n_ov));
    check("midrst_s", 64'(s), 64'd0);

    // 7. randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      din       = W'($urandom_range(0, 1));
      din_valid = ($urandom_range(0, 3) != 0);
      if (m_slot == 0) sync = ($urandom_range(0, 1) == 0);
      else             sync = ($urandom_range(0, 23) == 0);
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
